// File: rtl/endian_swap_arbiter.sv
// Two-requester round-robin arbiter feeding a single output register.
// The granted word is optionally byte-reversed on its way into the register,
// and a saturating counter tracks how many byte-reversed words were accepted.
module endian_swap_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic              req0_swap_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  input  logic              req1_swap_i,
  output logic              req1_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_src_o,
  input  logic              out_ready_i,
  output logic [15:0]       swap_cnt_o
);

  localparam int BYTE_N = DATA_W / 8;

  // ptr_q names the requester that wins when both are valid
  logic              ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic [15:0]       swap_cnt_q, swap_cnt_d;

  logic              load_en;
  logic              grant1;
  logic              accept;
  logic              sel_swap;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] rev_data;

  // Grant selection and ready handshakes; readies are held low while reset is asserted
  always_comb begin
    load_en      = reset & (~out_valid_q | out_ready_i);
    grant1       = req1_valid_i & (~req0_valid_i | ptr_q);
    req0_ready_o = load_en & req0_valid_i & ~grant1;
    req1_ready_o = load_en & req1_valid_i & grant1;
    accept       = req0_ready_o | req1_ready_o;
    sel_data     = grant1 ? req1_data_i : req0_data_i;
    sel_swap     = grant1 ? req1_swap_i : req0_swap_i;
  end

  // Byte reversal of the granted word; degenerates to a plain copy for one-byte words
  generate
    for (genvar gi = 0; gi < BYTE_N; gi++) begin : g_rev
      assign rev_data[gi*8 +: 8] = sel_data[(BYTE_N-1-gi)*8 +: 8];
    end
  endgenerate

  // Next-state: load on acceptance, drop valid on a pop with nothing new, count swaps
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    swap_cnt_d  = swap_cnt_q;
    if (accept) begin
      ptr_d       = ~grant1;
      out_valid_d = 1'b1;
      out_data_d  = sel_swap ? rev_data : sel_data;
      out_src_d   = grant1;
      if (sel_swap && (swap_cnt_q != 16'hFFFF)) begin
        swap_cnt_d = swap_cnt_q + 16'd1;
      end
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      swap_cnt_q  <= 16'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      swap_cnt_q  <= swap_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign swap_cnt_o  = swap_cnt_q;

endmodule

// File: tb/tb_endian_swap_arbiter.sv
// Scoreboard bench: a driver predicts grants and pushes expected words,
// a monitor compares the held output word against the queue front.
module tb_endian_swap_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid_i, req0_swap_i, req0_ready_o;
  logic [31:0] req0_data_i;
  logic        req1_valid_i, req1_swap_i, req1_ready_o;
  logic [31:0] req1_data_i;
  logic        out_valid_o, out_src_o, out_ready_i;
  logic [31:0] out_data_o;
  logic [15:0] swap_cnt_o;

  // 64-bit and 8-bit instances for width corner cases
  logic        w64_v0, w64_s0, w64_r0, w64_v1, w64_s1, w64_r1;
  logic        w64_ov, w64_src, w64_ordy;
  logic [63:0] w64_d0, w64_d1, w64_od;
  logic [15:0] w64_cnt;
  logic        w8_v0, w8_s0, w8_r0, w8_v1, w8_s1, w8_r1;
  logic        w8_ov, w8_src, w8_ordy;
  logic [7:0]  w8_d0, w8_d1, w8_od;
  logic [15:0] w8_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        src;
  } exp_t;

  exp_t        exp_q[$];
  logic        m_valid;
  int          m_ptr;
  logic [15:0] m_cnt;
  logic        mon_en;

  endian_swap_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_swap_i(req0_swap_i), .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_swap_i(req1_swap_i), .req1_ready_o(req1_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_src_o(out_src_o),
    .out_ready_i(out_ready_i), .swap_cnt_o(swap_cnt_o)
  );

  endian_swap_arbiter #(.DATA_W(64)) dut64 (
    .clk(clk), .reset(reset),
    .req0_valid_i(w64_v0), .req0_data_i(w64_d0), .req0_swap_i(w64_s0), .req0_ready_o(w64_r0),
    .req1_valid_i(w64_v1), .req1_data_i(w64_d1), .req1_swap_i(w64_s1), .req1_ready_o(w64_r1),
    .out_valid_o(w64_ov), .out_data_o(w64_od), .out_src_o(w64_src),
    .out_ready_i(w64_ordy), .swap_cnt_o(w64_cnt)
  );

  endian_swap_arbiter #(.DATA_W(8)) dut8 (
    .clk(clk), .reset(reset),
    .req0_valid_i(w8_v0), .req0_data_i(w8_d0), .req0_swap_i(w8_s0), .req0_ready_o(w8_r0),
    .req1_valid_i(w8_v1), .req1_data_i(w8_d1), .req1_swap_i(w8_s1), .req1_ready_o(w8_r1),
    .out_valid_o(w8_ov), .out_data_o(w8_od), .out_src_o(w8_src),
    .out_ready_i(w8_ordy), .swap_cnt_o(w8_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference conversion: output byte i comes from input byte 3-i when swapping
  function automatic logic [31:0] conv(input logic [31:0] d, input logic s);
    logic [31:0] r;
    r = d;
    if (s) begin
      for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(3-i) +: 8];
    end
    return r;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_valid = 1'b0;
    m_ptr   = 0;
    m_cnt   = 16'd0;
  endtask

  // One cycle: drive at the falling edge, predict the grant, check, then advance the model
  task automatic step(input logic v0, input logic [31:0] d0, input logic s0,
                      input logic v1, input logic [31:0] d1, input logic s1,
                      input logic ordy);
    int   g;
    logic load;
    exp_t e;
    @(negedge clk);
    req0_valid_i = v0; req0_data_i = d0; req0_swap_i = s0;
    req1_valid_i = v1; req1_data_i = d1; req1_swap_i = s1;
    out_ready_i  = ordy;
    #1;
    load = !m_valid || ordy;
    g = -1;
    if (load) begin
      if (v0 && v1) g = m_ptr;
      else if (v0)  g = 0;
      else if (v1)  g = 1;
    end
    chk("req0_ready", {63'd0, req0_ready_o}, {63'd0, g == 0});
    chk("req1_ready", {63'd0, req1_ready_o}, {63'd0, g == 1});
    chk("out_valid", {63'd0, out_valid_o}, {63'd0, m_valid});
    chk("swap_cnt", {48'd0, swap_cnt_o}, {48'd0, m_cnt});
    if (g >= 0) begin
      e.data = (g == 0) ? conv(d0, s0) : conv(d1, s1);
      e.src  = (g == 1);
      exp_q.push_back(e);
      if (((g == 0) ? s0 : s1) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      m_ptr   = 1 - g;
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
  endtask

  // Monitor: the held word must match the oldest expected entry; pop when downstream takes it
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en && out_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {32'd0, out_data_o}, 64'hDEAD_BEEF_0000_0000);
        end else begin
          chk("out_data", {32'd0, out_data_o}, {32'd0, exp_q[0].data});
          chk("out_src", {63'd0, out_src_o}, {63'd0, exp_q[0].src});
          if (out_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    mon_en = 1'b0;
    reset = 1'b0;
    req0_valid_i = 1'b1; req0_data_i = 32'h0; req0_swap_i = 1'b0;
    req1_valid_i = 1'b1; req1_data_i = 32'h0; req1_swap_i = 1'b0;
    out_ready_i = 1'b1;
    w64_v0 = 0; w64_d0 = '0; w64_s0 = 0; w64_v1 = 0; w64_d1 = '0; w64_s1 = 0; w64_ordy = 1;
    w8_v0 = 0;  w8_d0 = '0;  w8_s0 = 0;  w8_v1 = 0;  w8_d1 = '0;  w8_s1 = 0;  w8_ordy = 1;
    model_reset();

    // Reset state, with both requesters valid so the ready gating is visible
    #3;
    chk("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    chk("rst_out_data", {32'd0, out_data_o}, 64'd0);
    chk("rst_out_src", {63'd0, out_src_o}, 64'd0);
    chk("rst_swap_cnt", {48'd0, swap_cnt_o}, 64'd0);
    chk("rst_ready0", {63'd0, req0_ready_o}, 64'd0);
    chk("rst_ready1", {63'd0, req1_ready_o}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    reset = 1'b1;
    mon_en = 1'b1;

    // Single swapped word from requester 0
    step(1, 32'h11223344, 1, 0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1);
    chk("swap_word_literal", {32'd0, out_data_o}, {32'd0, 32'h44332211});

    // Both valid every cycle: grants alternate, one word per cycle
    for (int i = 0; i < 6; i++) step(1, 32'hA0A0A0A0, 0, 1, 32'h01020304, 1, 1);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1);

    // Backpressure: hold the output while requester 1 waits
    step(1, 32'hCAFEF00D, 0, 0, 32'h0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 32'h0, 0, 1, 32'h55667788, 1, 0);
    step(0, 32'h0, 0, 1, 32'h55667788, 1, 1);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1);

    // Counter saturation: preload near the top, then send swap words
    step(0, 32'h0, 0, 0, 32'h0, 0, 1);
    force dut.swap_cnt_d = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.swap_cnt_d;
    m_cnt = 16'hFFFE;
    for (int i = 0; i < 3; i++) step(1, 32'h01020304 + i, 1, 0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom, $urandom_range(0, 1),
           ($urandom % 4) != 0, $urandom, $urandom_range(0, 1),
           ($urandom % 4) != 0);
    end
    for (int i = 0; i < 3; i++) step(0, 32'h0, 0, 0, 32'h0, 0, 1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset mid-operation with a word held under backpressure
    step(1, 32'h12345678, 1, 0, 32'h0, 0, 0);
    step(0, 32'h0, 0, 0, 32'h0, 0, 0);
    mon_en = 1'b0;
    chk("pre_rst_valid", {63'd0, out_valid_o}, 64'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, out_valid_o}, 64'd0);
    chk("async_rst_data", {32'd0, out_data_o}, 64'd0);
    chk("async_rst_cnt", {48'd0, swap_cnt_o}, 64'd0);
    model_reset();
    @(negedge clk);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    reset = 1'b1;
    mon_en = 1'b1;
    step(1, 32'hAAAA5555, 0, 1, 32'hBBBB6666, 0, 1);
    step(1, 32'hAAAA5555, 0, 1, 32'hBBBB6666, 0, 1);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1);
    step(0, 32'h0, 0, 0, 32'h0, 0, 1);

    // Width corners: 64-bit reversal and 8-bit pass-through with counting
    @(negedge clk);
    w64_v0 = 1; w64_s0 = 1; w64_d0 = 64'h0102030405060708;
    w8_v0  = 1; w8_s0  = 1; w8_d0  = 8'hA5;
    #1;
    chk("w64_ready0", {63'd0, w64_r0}, 64'd1);
    @(negedge clk);
    w64_v0 = 0; w8_v0 = 0;
    #1;
    chk("w64_data", w64_od, 64'h0807060504030201);
    chk("w64_cnt", {48'd0, w64_cnt}, 64'd1);
    chk("w8_data", {56'd0, w8_od}, 64'h00000000000000A5);
    chk("w8_cnt", {48'd0, w8_cnt}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
